// File: rtl/mem_access_pkg.sv
`default_nettype none
// ============================================================================
// Module : mem_access_pkg
// Desc   : Memory-op codes, MEM-stage state encoding and op-class helpers.
// Rev    : 1.0 - initial release
// ============================================================================
package mem_access_pkg;

  typedef enum logic [2:0] {
    MEM_NOP = 3'd0,
    MEM_LB  = 3'd1,
    MEM_LBU = 3'd2,
    MEM_LW  = 3'd3,
    MEM_SB  = 3'd4,
    MEM_SW  = 3'd5
  } mem_op_e;

  typedef enum logic [0:0] {
    MEM_IDLE = 1'b0,
    MEM_BUSY = 1'b1
  } mem_state_e;

  function automatic logic is_load(input logic [2:0] op);
    return (op == MEM_LB) || (op == MEM_LBU) || (op == MEM_LW);
  endfunction

  function automatic logic is_store(input logic [2:0] op);
    return (op == MEM_SB) || (op == MEM_SW);
  endfunction

  function automatic logic is_word(input logic [2:0] op);
    return (op == MEM_LW) || (op == MEM_SW);
  endfunction

  // Codes 6 and 7 are unused and behave as NOP.
  function automatic logic is_mem_op(input logic [2:0] op);
    return is_load(op) || is_store(op);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_lane.sv
`default_nettype none
// ============================================================================
// Module : mem_lane
// Desc   : Big-endian byte-lane steering: store sel/wdata and load extraction.
// Rev    : 1.0 - initial release
// ============================================================================
module mem_lane
  import mem_access_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  sel,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0] w_byte;
  logic [3:0] w_byte_sel;

  // Offset 0 addresses the most significant lane.
  always_comb begin
    w_byte     = 8'h00;
    w_byte_sel = 4'b0000;
    unique case (offset)
      2'b00: begin w_byte = rdata[31:24]; w_byte_sel = 4'b1000; end
      2'b01: begin w_byte = rdata[23:16]; w_byte_sel = 4'b0100; end
      2'b10: begin w_byte = rdata[15:8];  w_byte_sel = 4'b0010; end
      2'b11: begin w_byte = rdata[7:0];   w_byte_sel = 4'b0001; end
    endcase
  end

  always_comb begin
    sel       = 4'b0000;
    wdata     = 32'h0000_0000;
    load_data = 32'h0000_0000;
    case (op)
      MEM_LB: begin
        sel       = w_byte_sel;
        load_data = {{24{w_byte[7]}}, w_byte};
      end
      MEM_LBU: begin
        sel       = w_byte_sel;
        load_data = {24'h00_0000, w_byte};
      end
      MEM_LW: begin
        sel       = 4'b1111;
        load_data = rdata;
      end
      MEM_SB: begin
        sel   = w_byte_sel;
        wdata = {4{store_data[7:0]}};
      end
      MEM_SW: begin
        sel   = 4'b1111;
        wdata = store_data;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
// Module : mem_access
// Desc   : MIPS32 MEM stage; registers EX results and runs loads/stores on a
//          req/ack bus, stalling the pipe until ack or timeout.
// Rev    : 1.0 - initial release
// ============================================================================
module mem_access
  import mem_access_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16,
  parameter int TO_W        = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        writeReg_i,
  input  logic [4:0]  writeAddr_i,
  input  logic [31:0] writeData_i,
  input  logic        wHiLo_i,
  input  logic [31:0] hiData_i,
  input  logic [31:0] loData_i,
  input  logic [2:0]  memOp_i,
  input  logic [31:0] memAddr_i,
  input  logic [31:0] storeData_i,
  input  logic [31:0] memRData_i,
  input  logic        memAck_i,
  output logic        writeReg_o,
  output logic [4:0]  writeAddr_o,
  output logic [31:0] writeData_o,
  output logic        wHiLo_o,
  output logic [31:0] hiData_o,
  output logic [31:0] loData_o,
  output logic        memReq_o,
  output logic        memWe_o,
  output logic [31:0] memAddr_o,
  output logic [3:0]  memSel_o,
  output logic [31:0] memWData_o,
  output logic        stallReq_o,
  output logic        busErr_o
);

  localparam logic [TO_W-1:0] c_cnt_limit = TO_W'(ACK_TIMEOUT - 1);

  mem_state_e      r_state;
  logic [TO_W-1:0] r_cnt;
  logic [2:0]      r_op;
  logic            r_hold_wreg;
  logic            r_hold_whilo;

  logic [2:0]  w_lane_op;
  logic [1:0]  w_lane_off;
  logic [3:0]  w_sel;
  logic [31:0] w_wdata;
  logic [31:0] w_load;

  // One lane unit serves both directions: IDLE aligns the incoming store,
  // BUSY extracts the load from the held op and the registered address.
  assign w_lane_op  = (r_state == MEM_IDLE) ? memOp_i         : r_op;
  assign w_lane_off = (r_state == MEM_IDLE) ? memAddr_i[1:0]  : memAddr_o[1:0];

  mem_lane u_lane (
    .op         (w_lane_op),
    .offset     (w_lane_off),
    .store_data (storeData_i),
    .rdata      (memRData_i),
    .sel        (w_sel),
    .wdata      (w_wdata),
    .load_data  (w_load)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= MEM_IDLE;
      r_cnt        <= '0;
      r_op         <= MEM_NOP;
      r_hold_wreg  <= 1'b0;
      r_hold_whilo <= 1'b0;
      writeReg_o   <= 1'b0;
      writeAddr_o  <= 5'd0;
      writeData_o  <= 32'h0;
      wHiLo_o      <= 1'b0;
      hiData_o     <= 32'h0;
      loData_o     <= 32'h0;
      memReq_o     <= 1'b0;
      memWe_o      <= 1'b0;
      memAddr_o    <= 32'h0;
      memSel_o     <= 4'h0;
      memWData_o   <= 32'h0;
      stallReq_o   <= 1'b0;
      busErr_o     <= 1'b0;
    end else begin
      busErr_o <= 1'b0;
      case (r_state)
        MEM_IDLE: begin
          if (stall_i) begin
            r_op        <= MEM_NOP;
            writeReg_o  <= 1'b0;
            writeAddr_o <= 5'd0;
            writeData_o <= 32'h0;
            wHiLo_o     <= 1'b0;
            hiData_o    <= 32'h0;
            loData_o    <= 32'h0;
            memReq_o    <= 1'b0;
            memWe_o     <= 1'b0;
            memAddr_o   <= 32'h0;
            memSel_o    <= 4'h0;
            memWData_o  <= 32'h0;
            stallReq_o  <= 1'b0;
          end else begin
            r_op         <= memOp_i;
            r_hold_wreg  <= writeReg_i;
            r_hold_whilo <= wHiLo_i;
            r_cnt        <= '0;
            writeAddr_o  <= writeAddr_i;
            writeData_o  <= writeData_i;
            hiData_o     <= hiData_i;
            loData_o     <= loData_i;
            memSel_o     <= w_sel;
            memWData_o   <= w_wdata;
            if (is_mem_op(memOp_i)) begin
              r_state    <= MEM_BUSY;
              writeReg_o <= 1'b0;
              wHiLo_o    <= 1'b0;
              memReq_o   <= 1'b1;
              stallReq_o <= 1'b1;
              memWe_o    <= is_store(memOp_i);
              memAddr_o  <= is_word(memOp_i) ? {memAddr_i[31:2], 2'b00} : memAddr_i;
            end else begin
              writeReg_o <= writeReg_i;
              wHiLo_o    <= wHiLo_i;
              memReq_o   <= 1'b0;
              stallReq_o <= 1'b0;
              memWe_o    <= 1'b0;
              memAddr_o  <= memAddr_i;
            end
          end
        end

        MEM_BUSY: begin
          // Ack is tested first so an ack on the limit cycle still completes.
          if (memAck_i) begin
            r_state    <= MEM_IDLE;
            memReq_o   <= 1'b0;
            stallReq_o <= 1'b0;
            memWe_o    <= 1'b0;
            memSel_o   <= 4'h0;
            memWData_o <= 32'h0;
            wHiLo_o    <= r_hold_whilo;
            if (is_load(r_op)) begin
              writeReg_o  <= r_hold_wreg;
              writeData_o <= w_load;
            end else begin
              writeReg_o <= 1'b0;
            end
          end else if (r_cnt == c_cnt_limit) begin
            r_state    <= MEM_IDLE;
            memReq_o   <= 1'b0;
            stallReq_o <= 1'b0;
            memWe_o    <= 1'b0;
            memSel_o   <= 4'h0;
            memWData_o <= 32'h0;
            writeReg_o <= 1'b0;
            wHiLo_o    <= 1'b0;
            busErr_o   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + TO_W'(1);
          end
        end

        default: r_state <= MEM_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_access
// Desc   : Randomized self-checking bench for mem_access with a
//          transaction-level reference model and per-cycle output compare.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_mem_access;

  localparam int ACK_TIMEOUT = 16;
  localparam int TO_W        = 5;
  localparam logic [2:0] OP_NOP = 3'd0, OP_LB = 3'd1, OP_LBU = 3'd2,
                         OP_LW  = 3'd3, OP_SB = 3'd4, OP_SW  = 3'd5;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i, writeReg_i, wHiLo_i, memAck_i;
  logic [4:0]  writeAddr_i;
  logic [31:0] writeData_i, hiData_i, loData_i, memAddr_i, storeData_i, memRData_i;
  logic [2:0]  memOp_i;
  logic        writeReg_o, wHiLo_o, memReq_o, memWe_o, stallReq_o, busErr_o;
  logic [4:0]  writeAddr_o;
  logic [31:0] writeData_o, hiData_o, loData_o, memAddr_o, memWData_o;
  logic [3:0]  memSel_o;

  always #5 clk = ~clk;

  mem_access #(.ACK_TIMEOUT(ACK_TIMEOUT), .TO_W(TO_W)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i),
    .writeReg_i(writeReg_i), .writeAddr_i(writeAddr_i), .writeData_i(writeData_i),
    .wHiLo_i(wHiLo_i), .hiData_i(hiData_i), .loData_i(loData_i),
    .memOp_i(memOp_i), .memAddr_i(memAddr_i), .storeData_i(storeData_i),
    .memRData_i(memRData_i), .memAck_i(memAck_i),
    .writeReg_o(writeReg_o), .writeAddr_o(writeAddr_o), .writeData_o(writeData_o),
    .wHiLo_o(wHiLo_o), .hiData_o(hiData_o), .loData_o(loData_o),
    .memReq_o(memReq_o), .memWe_o(memWe_o), .memAddr_o(memAddr_o),
    .memSel_o(memSel_o), .memWData_o(memWData_o),
    .stallReq_o(stallReq_o), .busErr_o(busErr_o)
  );

  typedef struct {
    logic        wreg;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi, lo;
    logic        req, we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] bwdata;
    logic        stall_req, bus_err;
    logic        chk_bus;
  } exp_t;

  typedef struct {
    logic        stall;
    logic [2:0]  op;
    logic        wreg;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi, lo, addr, sdata;
  } instr_t;

  exp_t        exp_q;
  bit          chk_en = 1'b0;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] snap_addr, snap_wdata;
  logic [3:0]  snap_sel;
  logic        snap_we;
  int          stall_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // ---------------- reference model (byte-lane arithmetic) ----------------
  function automatic bit m_is_load(input logic [2:0] op);
    return op == OP_LB || op == OP_LBU || op == OP_LW;
  endfunction

  function automatic bit m_is_word(input logic [2:0] op);
    return op == OP_LW || op == OP_SW;
  endfunction

  function automatic logic [3:0] m_sel(input logic [2:0] op, input logic [31:0] addr);
    int sh;
    if (m_is_word(op)) return 4'hF;
    if (op == OP_LB || op == OP_LBU || op == OP_SB) begin
      sh = 3 - int'(addr[1:0]);
      return 4'(1 << sh);
    end
    return 4'h0;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] op, input logic [31:0] sdata);
    if (op == OP_SB) return 32'(sdata[7:0]) * 32'h0101_0101;
    if (op == OP_SW) return sdata;
    return 32'h0;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] op, input logic [31:0] addr,
                                         input logic [31:0] rdata);
    int sh;
    logic [31:0] b;
    sh = 8 * (3 - int'(addr[1:0]));
    b  = (rdata >> sh) & 32'hFF;
    if (op == OP_LW)  return rdata;
    if (op == OP_LBU) return b;
    if (op == OP_LB)  return (b >= 32'd128) ? b - 32'd256 : b;
    return 32'h0;
  endfunction

  function automatic exp_t mk_idle();
    exp_t e;
    e.wreg = 1'b0; e.waddr = 5'd0; e.wdata = 32'h0; e.whilo = 1'b0;
    e.hi = 32'h0; e.lo = 32'h0; e.req = 1'b0; e.we = 1'b0; e.addr = 32'h0;
    e.sel = 4'h0; e.bwdata = 32'h0; e.stall_req = 1'b0; e.bus_err = 1'b0;
    e.chk_bus = 1'b1;
    return e;
  endfunction

  function automatic instr_t rand_instr();
    instr_t t;
    t.stall = ($urandom_range(0, 5) == 0);
    t.op    = 3'($urandom_range(0, 5));
    t.wreg  = 1'($urandom_range(0, 1));
    t.waddr = 5'($urandom);
    t.wdata = $urandom;
    t.whilo = 1'($urandom_range(0, 1));
    t.hi    = $urandom;
    t.lo    = $urandom;
    t.addr  = $urandom;
    t.sdata = $urandom;
    return t;
  endfunction

  task automatic drive_garbage();
    stall_i     = 1'($urandom);
    writeReg_i  = 1'($urandom);
    writeAddr_i = 5'($urandom);
    writeData_i = $urandom;
    wHiLo_i     = 1'($urandom);
    hiData_i    = $urandom;
    loData_i    = $urandom;
    memOp_i     = 3'($urandom);
    memAddr_i   = $urandom;
    storeData_i = $urandom;
  endtask

  // Present one instruction; d = busy cycle carrying the ack (d > ACK_TIMEOUT: none).
  // Returns 1ns after the edge that starts the result cycle, with exp_q set for it.
  task automatic issue(input instr_t t, input int d, input logic [31:0] rdata, input bit idle_ack);
    exp_t e;
    int   busy_len;
    bit   tmo;
    stall_i = t.stall; writeReg_i = t.wreg; writeAddr_i = t.waddr; writeData_i = t.wdata;
    wHiLo_i = t.whilo; hiData_i = t.hi; loData_i = t.lo; memOp_i = t.op;
    memAddr_i = t.addr; storeData_i = t.sdata;
    memAck_i = idle_ack; memRData_i = $urandom;
    @(posedge clk); #1;
    e = mk_idle();
    if (t.stall) begin
      exp_q = e;
      return;
    end
    if (t.op == OP_NOP) begin
      e.wreg = t.wreg; e.waddr = t.waddr; e.wdata = t.wdata;
      e.whilo = t.whilo; e.hi = t.hi; e.lo = t.lo;
      exp_q = e;
      return;
    end
    tmo      = (d > ACK_TIMEOUT);
    busy_len = tmo ? ACK_TIMEOUT : d;
    e.req = 1'b1; e.stall_req = 1'b1; e.chk_bus = 1'b0;
    e.we     = (t.op == OP_SB || t.op == OP_SW);
    e.addr   = m_is_word(t.op) ? (t.addr & ~32'h3) : t.addr;
    e.sel    = m_sel(t.op, t.addr);
    e.bwdata = m_wdata(t.op, t.sdata);
    stall_cnt = 0;
    for (int k = 1; k <= busy_len; k++) begin
      exp_q = e;
      if (k == 1) begin
        snap_addr = memAddr_o; snap_sel = memSel_o; snap_wdata = memWData_o; snap_we = memWe_o;
      end
      if (stallReq_o) stall_cnt++;
      drive_garbage();
      memAck_i   = (k == d);
      memRData_i = (k == d) ? rdata : $urandom;
      @(posedge clk); #1;
    end
    e = mk_idle();
    e.chk_bus = 1'b0;
    e.bus_err = tmo;
    e.wreg    = !tmo && m_is_load(t.op) && t.wreg;
    e.waddr   = t.waddr;
    e.wdata   = m_load(t.op, t.addr, rdata);
    e.whilo   = !tmo && t.whilo;
    e.hi      = t.hi;
    e.lo      = t.lo;
    exp_q = e;
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("writeReg_o", 32'(writeReg_o), 32'(exp_q.wreg));
      if (exp_q.wreg) begin
        check("writeAddr_o", 32'(writeAddr_o), 32'(exp_q.waddr));
        check("writeData_o", writeData_o, exp_q.wdata);
      end
      check("wHiLo_o", 32'(wHiLo_o), 32'(exp_q.whilo));
      if (exp_q.whilo) begin
        check("hiData_o", hiData_o, exp_q.hi);
        check("loData_o", loData_o, exp_q.lo);
      end
      check("memReq_o", 32'(memReq_o), 32'(exp_q.req));
      check("stallReq_o", 32'(stallReq_o), 32'(exp_q.stall_req));
      check("busErr_o", 32'(busErr_o), 32'(exp_q.bus_err));
      if (exp_q.req) begin
        check("memWe_o", 32'(memWe_o), 32'(exp_q.we));
        check("memAddr_o", memAddr_o, exp_q.addr);
        check("memSel_o", 32'(memSel_o), 32'(exp_q.sel));
        check("memWData_o", memWData_o, exp_q.bwdata);
      end else if (exp_q.chk_bus) begin
        check("memWe_o_idle", 32'(memWe_o), 32'(exp_q.we));
        check("memSel_o_idle", 32'(memSel_o), 32'(exp_q.sel));
        check("memWData_o_idle", memWData_o, exp_q.bwdata);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    instr_t t;
    int     d;
    rst = 1'b1;
    stall_i = 0; writeReg_i = 0; writeAddr_i = 0; writeData_i = 0; wHiLo_i = 0;
    hiData_i = 0; loData_i = 0; memOp_i = 0; memAddr_i = 0; storeData_i = 0;
    memRData_i = 0; memAck_i = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_writeReg", 32'(writeReg_o), 32'h0);
    check("reset_memReq", 32'(memReq_o), 32'h0);
    check("reset_stallReq", 32'(stallReq_o), 32'h0);
    #2 rst = 1'b0;
    exp_q = mk_idle();
    chk_en = 1'b1;

    // ALU pass-through
    t = rand_instr(); t.stall = 0; t.op = OP_NOP; t.wreg = 1; t.waddr = 5'd3;
    t.wdata = 32'h1234_5678;
    issue(t, 1, 32'h0, 1'b0);
    check("alu_writeReg", 32'(writeReg_o), 32'h1);
    check("alu_writeAddr", 32'(writeAddr_o), 32'h3);
    check("alu_writeData", writeData_o, 32'h1234_5678);
    check("alu_stallReq", 32'(stallReq_o), 32'h0);

    // LW, ack in third busy cycle
    t = rand_instr(); t.stall = 0; t.op = OP_LW; t.wreg = 1; t.addr = 32'h0000_0102;
    issue(t, 3, 32'hDEAD_BEEF, 1'b0);
    check("lw_addr", snap_addr, 32'h0000_0100);
    check("lw_sel", 32'(snap_sel), 32'hF);
    check("lw_stall_cycles", 32'(stall_cnt), 32'd3);
    check("lw_data", writeData_o, 32'hDEAD_BEEF);
    check("lw_writeReg", 32'(writeReg_o), 32'h1);

    // LB / LBU on lane [15:8]
    t = rand_instr(); t.stall = 0; t.op = OP_LB; t.wreg = 1; t.addr = 32'h0000_0402;
    issue(t, 2, 32'h0011_8022, 1'b0);
    check("lb_data", writeData_o, 32'hFFFF_FF80);
    t.op = OP_LBU;
    issue(t, 1, 32'h0011_8022, 1'b0);
    check("lbu_data", writeData_o, 32'h0000_0080);

    // SB on lane [23:16]
    t = rand_instr(); t.stall = 0; t.op = OP_SB; t.wreg = 1; t.addr = 32'h0000_2001;
    t.sdata = 32'h0000_00AB;
    issue(t, 2, 32'h0, 1'b0);
    check("sb_sel", 32'(snap_sel), 32'h4);
    check("sb_wdata", snap_wdata, 32'hABAB_ABAB);
    check("sb_we", 32'(snap_we), 32'h1);
    check("sb_writeReg", 32'(writeReg_o), 32'h0);

    // No ack: bus error, then late ack ignored while an MTHI passes through
    t = rand_instr(); t.stall = 0; t.op = OP_LW; t.wreg = 1;
    issue(t, ACK_TIMEOUT + 1, 32'h0, 1'b0);
    check("tmo_busErr", 32'(busErr_o), 32'h1);
    check("tmo_writeReg", 32'(writeReg_o), 32'h0);
    t = rand_instr(); t.stall = 0; t.op = OP_NOP; t.wreg = 0; t.whilo = 1; t.hi = 32'h5;
    issue(t, 1, 32'h0, 1'b1);
    check("mthi_wHiLo", 32'(wHiLo_o), 32'h1);
    check("mthi_hiData", hiData_o, 32'h5);
    check("mthi_busErr", 32'(busErr_o), 32'h0);

    // Ack on the limit cycle wins over the timeout
    t = rand_instr(); t.stall = 0; t.op = OP_LW; t.wreg = 1;
    issue(t, ACK_TIMEOUT, 32'hCAFE_0001, 1'b0);
    check("limit_busErr", 32'(busErr_o), 32'h0);
    check("limit_data", writeData_o, 32'hCAFE_0001);

    // Async reset in the middle of a transaction
    stall_i = 0; memOp_i = OP_SW; memAddr_i = 32'h40; storeData_i = 32'h1; memAck_i = 0;
    @(posedge clk); #1;
    chk_en = 1'b0;
    check("rst_pre_req", 32'(memReq_o), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_req", 32'(memReq_o), 32'h0);
    check("rst_async_stall", 32'(stallReq_o), 32'h0);
    @(posedge clk); #1;
    check("rst_writeReg", 32'(writeReg_o), 32'h0);
    check("rst_writeData", writeData_o, 32'h0);
    check("rst_wHiLo", 32'(wHiLo_o), 32'h0);
    check("rst_memAddr", memAddr_o, 32'h0);
    check("rst_memSel", 32'(memSel_o), 32'h0);
    check("rst_memWe", 32'(memWe_o), 32'h0);
    check("rst_busErr", 32'(busErr_o), 32'h0);
    #2 rst = 1'b0;
    exp_q = mk_idle();
    chk_en = 1'b1;

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      t = rand_instr();
      case ($urandom_range(0, 9))
        0:       d = $urandom_range(ACK_TIMEOUT + 1, ACK_TIMEOUT + 3);
        1:       d = ACK_TIMEOUT;
        default: d = $urandom_range(1, 6);
      endcase
      issue(t, d, $urandom, ($urandom_range(0, 3) == 0));
    end

    t = rand_instr(); t.stall = 1;
    issue(t, 1, 32'h0, 1'b0);
    @(negedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
